// File: rtl/uiimx415_i2c_slave.sv
`timescale 1ns/1ps
// ============================================================================
// uiimx415_i2c_slave
// ----------------------------------------------------------------------------
// I2C target that gives a bus master access to a 16-bit addressed, 8-bit wide
// register file. A write transaction carries a two-byte register pointer
// (high byte first) followed by any number of data bytes. Each data byte
// raises a write strobe and then advances the pointer. A read transaction
// streams bytes from the current pointer. The pointer advances on every
// master ACK, and a master NACK ends the stream.
//
// SCL and SDA are asynchronous to I_clk. Both are resynchronised, and all bus
// events are derived from the synchronised copies. I_clk must run at least
// 20x faster than SCL.
//
// Ports
//   I_clk        system clock, rising edge only
//   I_rst_n      synchronous active-low reset
//   I_scl        bus clock from the master
//   IO_sda       bus data, open-drain (driven low or released, never high)
//   O_reg_wr     one-cycle write strobe
//   O_reg_addr   current register pointer
//   O_reg_wdata  write data, valid while O_reg_wr is high
//   O_reg_rd     one-cycle read-fetch strobe
//   I_reg_rdata  read data for O_reg_addr, taken the cycle after O_reg_rd
//   O_busy       high while this target is addressed
// ============================================================================
module uiimx415_i2c_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_scl,
    inout  wire         IO_sda,
    output logic        O_reg_wr,
    output logic [15:0] O_reg_addr,
    output logic [7:0]  O_reg_wdata,
    output logic        O_reg_rd,
    input  logic [7:0]  I_reg_rdata,
    output logic        O_busy
);

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        ACK_DEV,
        AH,
        ACK_AH,
        AL,
        ACK_AL,
        WDAT,
        ACK_W,
        RDAT,
        MACK,
        IGNORE
    } state_t;

    // Synchroniser chain: meta -> sync. The prev stage holds the previous
    // synchronised value and is used for edge detection.
    logic       scl_meta_q, scl_sync_q, scl_prev_q;
    logic       sda_meta_q, sda_sync_q, sda_prev_q;
    logic [1:0] settle_q;

    logic       sync_ok;
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;

    state_t      state_q,   state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q,   shreg_d;
    logic        rw_q,      rw_d;
    logic [15:0] ptr_q,     ptr_d;
    logic [7:0]  wdata_q,   wdata_d;
    logic        wr_q,      wr_d;
    logic        rd_q,      rd_d;
    logic        rd_pend_q, rd_pend_d;
    logic        oe_q,      oe_d;
    logic        busy_q,    busy_d;

    logic [7:0]  byte_in;
    logic        last_bit;

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
            settle_q   <= 2'd0;
        end else begin
            scl_meta_q <= I_scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= IO_sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
        end
    end

    // After reset, the chain still holds its forced-high values. Bus edges
    // are suppressed until real samples reach the prev stage, so that reset
    // released in the middle of a transfer cannot create a phantom START.
    assign sync_ok   = (settle_q == 2'd3);
    assign scl_rise  = sync_ok &  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = sync_ok & ~scl_sync_q &  scl_prev_q;
    assign start_det = sync_ok & scl_sync_q & scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_det  = sync_ok & scl_sync_q & scl_prev_q & ~sda_prev_q &  sda_sync_q;

    assign byte_in  = {shreg_q[6:0], sda_sync_q};
    assign last_bit = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        rd_pend_d = rd_q;
        oe_d      = oe_q;
        busy_d    = busy_q;

        // Fetched read byte arrives one cycle after the strobe. Present its
        // MSB immediately; SCL is still low from the edge that issued the fetch.
        if (rd_pend_q && (state_q == RDAT)) begin
            shreg_d = I_reg_rdata;
            oe_d    = ~I_reg_rdata[7];
        end

        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = DEV;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
        end else begin
            unique case (state_q)
                DEV, AH, AL, WDAT: begin
                    if (scl_rise) begin
                        shreg_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (last_bit) begin
                            unique case (state_q)
                                DEV: begin
                                    if (byte_in[7:1] == DEV_ADDR) begin
                                        state_d = ACK_DEV;
                                        rw_d    = byte_in[0];
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = IGNORE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                AH: begin
                                    ptr_d[15:8] = byte_in;
                                    state_d     = ACK_AH;
                                end
                                AL: begin
                                    ptr_d[7:0] = byte_in;
                                    state_d    = ACK_AL;
                                end
                                default: begin
                                    wdata_d = byte_in;
                                    wr_d    = 1'b1;
                                    state_d = ACK_W;
                                end
                            endcase
                        end
                    end
                end

                // ACK handling: the first falling edge pulls SDA low, and the
                // second falling edge (end of bit 9) releases it and moves on.
                ACK_DEV, ACK_AH, ACK_AL, ACK_W: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d      = 1'b0;
                            bit_cnt_d = 3'd0;
                            unique case (state_q)
                                ACK_DEV: begin
                                    if (rw_q) begin
                                        state_d = RDAT;
                                        rd_d    = 1'b1;
                                    end else begin
                                        state_d = AH;
                                    end
                                end
                                ACK_AH: state_d = AL;
                                ACK_AL: state_d = WDAT;
                                default: begin
                                    state_d = WDAT;
                                    ptr_d   = ptr_q + 16'd1;
                                end
                            endcase
                        end
                    end
                end

                // Bit count wraps to 0 after the eighth rising edge. The
                // falling edge that follows releases SDA for the master's ACK.
                RDAT: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            oe_d    = 1'b0;
                            state_d = MACK;
                        end else begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            oe_d    = ~shreg_q[6];
                        end
                    end
                end

                // Pointer advances when the ACK is sampled, so the fetch issued
                // on the following falling edge already sees the new address.
                MACK: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr_q + 16'd1;
                        end
                    end else if (scl_fall) begin
                        state_d   = RDAT;
                        bit_cnt_d = 3'd0;
                        rd_d      = 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            ptr_q     <= 16'h0000;
            wdata_q   <= 8'h00;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            rd_pend_q <= rd_pend_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
        end
    end

    // Pure datapath registers: they are always reloaded before use.
    always_ff @(posedge I_clk) begin
        shreg_q <= shreg_d;
        rw_q    <= rw_d;
    end

    assign IO_sda      = oe_q ? 1'b0 : 1'bz;
    assign O_reg_wr    = wr_q;
    assign O_reg_rd    = rd_q;
    assign O_reg_addr  = ptr_q;
    assign O_reg_wdata = wdata_q;
    assign O_busy      = busy_q;

endmodule
